// File: rtl/tri_pkg.sv
// Shared widths and record layouts for the triangle assembly stage.
// The default-width types describe the canonical 16-bit record handed to the rasterizer.
package tri_pkg;

    localparam int TRI_COORD_W = 16;
    localparam int TRI_COLOR_W = 16;
    localparam int TRI_NVTX    = 3;

    typedef logic signed [TRI_COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } vertex_t;

    typedef struct packed {
        coord_t ymax;
        coord_t ymin;
        coord_t xmax;
        coord_t xmin;
    } bbox_t;

    typedef struct packed {
        vertex_t [TRI_NVTX-1:0]  v;
        logic [TRI_COLOR_W-1:0]  color;
        bbox_t                   bbox;
        logic                    degen;
        logic                    last;
    } tri_rec_t;

endpackage

// File: rtl/tri_fifo.sv
// Record FIFO with extra-MSB pointers; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module tri_fifo #(
    parameter type rec_t = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic push,
    input  logic pop,
    input  rec_t din,
    output rec_t head,
    output logic valid,
    output logic drop
);
    localparam int AW = $clog2(DEPTH);

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign valid   = !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data-only; the top masks the head while empty.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tri_assembler.sv
// Groups every three vertex beats into a triangle record with bbox/degen,
// buffers records in tri_fifo and hands them to the rasterizer on valid/ready.
module tri_assembler
    import tri_pkg::*;
#(
    parameter int COORD_W = TRI_COORD_W,
    parameter int COLOR_W = TRI_COLOR_W,
    parameter int DEPTH   = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    input  logic [COORD_W-1:0]     vertex_x,
    input  logic [COORD_W-1:0]     vertex_y,
    input  logic [COORD_W-1:0]     vertex_z,
    input  logic [COLOR_W-1:0]     color_in,
    input  logic                   last_in,
    output logic                   tri_valid_out,
    input  logic                   tri_ready_in,
    output logic [3*COORD_W-1:0]   tri_x_out,
    output logic [3*COORD_W-1:0]   tri_y_out,
    output logic [3*COORD_W-1:0]   tri_z_out,
    output logic [COLOR_W-1:0]     tri_color_out,
    output logic [4*COORD_W-1:0]   bbox_out,
    output logic                   degen_out,
    output logic                   tri_last_out,
    output logic                   overflow_out,
    output logic                   frame_err_out
);
    typedef logic signed [COORD_W-1:0] crd_t;

    typedef struct packed {
        crd_t x;
        crd_t y;
        crd_t z;
    } vtx_t;

    typedef struct packed {
        crd_t ymax;
        crd_t ymin;
        crd_t xmax;
        crd_t xmin;
    } box_t;

    typedef struct packed {
        vtx_t [TRI_NVTX-1:0] v;
        logic [COLOR_W-1:0]  color;
        box_t                bbox;
        logic                degen;
        logic                last;
    } rec_t;

    function automatic crd_t min3(crd_t a, crd_t b, crd_t c);
        crd_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic crd_t max3(crd_t a, crd_t b, crd_t c);
        crd_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    vtx_t               cur;
    vtx_t [1:0]         stg;
    logic [COLOR_W-1:0] stg_color;
    logic [1:0]         idx;
    logic               push;
    logic               fifo_drop;
    rec_t               rec;
    rec_t               head;
    rec_t               head_m;

    assign cur  = '{x: vertex_x, y: vertex_y, z: vertex_z};
    assign push = valid_in && (idx == 2'd2);

    // Third vertex comes straight from the input beat so the record is pushed this cycle.
    always_comb begin
        rec            = '0;
        rec.v          = {cur, stg[1], stg[0]};
        rec.color      = stg_color;
        rec.bbox.xmin  = min3(stg[0].x, stg[1].x, cur.x);
        rec.bbox.xmax  = max3(stg[0].x, stg[1].x, cur.x);
        rec.bbox.ymin  = min3(stg[0].y, stg[1].y, cur.y);
        rec.bbox.ymax  = max3(stg[0].y, stg[1].y, cur.y);
        rec.degen      = (rec.bbox.xmin == rec.bbox.xmax) || (rec.bbox.ymin == rec.bbox.ymax);
        rec.last       = last_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx           <= '0;
            stg           <= '0;
            stg_color     <= '0;
            overflow_out  <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            if (fifo_drop) overflow_out <= 1'b1;
            if (valid_in) begin
                if (idx == 2'd2) begin
                    idx <= '0;
                end else if (last_in) begin
                    idx           <= '0;
                    frame_err_out <= 1'b1;
                end else begin
                    stg[idx[0]] <= cur;
                    if (idx == 2'd0) stg_color <= color_in;
                    idx <= idx + 2'd1;
                end
            end
        end
    end

    tri_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push),
        .pop    (tri_ready_in),
        .din    (rec),
        .head   (head),
        .valid  (tri_valid_out),
        .drop   (fifo_drop)
    );

    // Head is forced to zero while empty so reset drives every output low at once.
    assign head_m = tri_valid_out ? head : '0;

    for (genvar g = 0; g < TRI_NVTX; g++) begin : g_vtx
        assign tri_x_out[g*COORD_W +: COORD_W] = head_m.v[g].x;
        assign tri_y_out[g*COORD_W +: COORD_W] = head_m.v[g].y;
        assign tri_z_out[g*COORD_W +: COORD_W] = head_m.v[g].z;
    end

    assign tri_color_out = head_m.color;
    assign bbox_out      = head_m.bbox;
    assign degen_out     = head_m.degen;
    assign tri_last_out  = head_m.last;

endmodule

// File: tb/tb_tri_assembler.sv
// Randomized scoreboard bench for tri_assembler: a queue-based reference model
// predicts records and sticky flags; a monitor checks each accepted head.
module tb_tri_assembler;
    localparam int CW    = 16;
    localparam int KW    = 16;
    localparam int DEPTH = 8;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            valid_in = 1'b0;
    logic [CW-1:0]   vertex_x = '0;
    logic [CW-1:0]   vertex_y = '0;
    logic [CW-1:0]   vertex_z = '0;
    logic [KW-1:0]   color_in = '0;
    logic            last_in = 1'b0;
    logic            tri_ready_in = 1'b0;
    logic            tri_valid_out;
    logic [3*CW-1:0] tri_x_out;
    logic [3*CW-1:0] tri_y_out;
    logic [3*CW-1:0] tri_z_out;
    logic [KW-1:0]   tri_color_out;
    logic [4*CW-1:0] bbox_out;
    logic            degen_out;
    logic            tri_last_out;
    logic            overflow_out;
    logic            frame_err_out;

    tri_assembler #(.COORD_W(CW), .COLOR_W(KW), .DEPTH(DEPTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .vertex_x      (vertex_x),
        .vertex_y      (vertex_y),
        .vertex_z      (vertex_z),
        .color_in      (color_in),
        .last_in       (last_in),
        .tri_valid_out (tri_valid_out),
        .tri_ready_in  (tri_ready_in),
        .tri_x_out     (tri_x_out),
        .tri_y_out     (tri_y_out),
        .tri_z_out     (tri_z_out),
        .tri_color_out (tri_color_out),
        .bbox_out      (bbox_out),
        .degen_out     (degen_out),
        .tri_last_out  (tri_last_out),
        .overflow_out  (overflow_out),
        .frame_err_out (frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3*CW-1:0] x;
        logic [3*CW-1:0] y;
        logic [3*CW-1:0] z;
        logic [KW-1:0]   col;
        logic [4*CW-1:0] bbox;
        logic            degen;
        logic            last;
    } exp_t;

    exp_t exp_q[$];
    int   vx[$], vy[$], vz[$];
    int   vcol;
    int   occ   = 0;
    bit   m_ovf = 0;
    bit   m_ferr = 0;
    int   vecs  = 0;
    int   errs  = 0;
    int   n_out = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int mn3(int a, int b, int c);
        int m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic int mx3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic exp_t mk_rec(bit last);
        exp_t e;
        int xmn, xmx, ymn, ymx;
        xmn     = mn3(vx[0], vx[1], vx[2]);
        xmx     = mx3(vx[0], vx[1], vx[2]);
        ymn     = mn3(vy[0], vy[1], vy[2]);
        ymx     = mx3(vy[0], vy[1], vy[2]);
        e.x     = {16'(vx[2]), 16'(vx[1]), 16'(vx[0])};
        e.y     = {16'(vy[2]), 16'(vy[1]), 16'(vy[0])};
        e.z     = {16'(vz[2]), 16'(vz[1]), 16'(vz[0])};
        e.col   = 16'(vcol);
        e.bbox  = {16'(ymx), 16'(ymn), 16'(xmx), 16'(xmn)};
        e.degen = (xmn == xmx) || (ymn == ymx);
        e.last  = last;
        return e;
    endfunction

    // Reference model: inputs are stable at the falling edge and take effect at the next rise.
    always @(negedge clk_in) begin
        int   occ_pre;
        bit   pop;
        exp_t e;
        if (!rst_in) begin
            exp_q.delete();
            vx.delete(); vy.delete(); vz.delete();
            occ = 0; m_ovf = 0; m_ferr = 0;
        end else begin
            chk("tri_valid", 64'(tri_valid_out), 64'(occ > 0));
            chk("overflow", 64'(overflow_out), 64'(m_ovf));
            chk("frame_err", 64'(frame_err_out), 64'(m_ferr));
            occ_pre = occ;
            pop = (occ_pre > 0) && tri_ready_in;
            if (pop) occ--;
            if (valid_in) begin
                if (vx.size() == 2) begin
                    vx.push_back(int'($signed(vertex_x)));
                    vy.push_back(int'($signed(vertex_y)));
                    vz.push_back(int'($signed(vertex_z)));
                    e = mk_rec(last_in);
                    if (occ_pre < DEPTH || pop) begin
                        exp_q.push_back(e);
                        occ++;
                    end else begin
                        m_ovf = 1;
                    end
                    vx.delete(); vy.delete(); vz.delete();
                end else if (last_in) begin
                    vx.delete(); vy.delete(); vz.delete();
                    m_ferr = 1;
                end else begin
                    if (vx.size() == 0) vcol = int'(color_in);
                    vx.push_back(int'($signed(vertex_x)));
                    vy.push_back(int'($signed(vertex_y)));
                    vz.push_back(int'($signed(vertex_z)));
                end
            end
        end
    end

    // Monitor: every head the rasterizer takes must match the oldest predicted record.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && tri_valid_out && tri_ready_in) begin
            if (exp_q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected_tri: got x=%0h, expected no record at %0t", tri_x_out, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rec_x", 64'(tri_x_out), 64'(e.x));
                chk("rec_y", 64'(tri_y_out), 64'(e.y));
                chk("rec_z", 64'(tri_z_out), 64'(e.z));
                chk("rec_color", 64'(tri_color_out), 64'(e.col));
                chk("rec_bbox", bbox_out, e.bbox);
                chk("rec_degen", 64'(degen_out), 64'(e.degen));
                chk("rec_last", 64'(tri_last_out), 64'(e.last));
            end
            n_out++;
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic beat(int x, int y, int z, int col, bit last);
        valid_in = 1'b1;
        vertex_x = 16'(x);
        vertex_y = 16'(y);
        vertex_z = 16'(z);
        color_in = 16'(col);
        last_in  = last;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    function automatic int rc();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 8)) - 4;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic rbeat(bit last);
        beat(rc(), rc(), rc(), int'($urandom_range(0, 65535)), last);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        idle(2);
        rst_in = 1'b1;
        idle(1);
    endtask

    task automatic drain(int bound);
        int k = 0;
        tri_ready_in = 1'b1;
        while ((exp_q.size() > 0 || tri_valid_out) && k < bound) begin
            idle(1);
            k++;
        end
        if (k >= bound) begin
            vecs++; errs++;
            $display("FAIL drain_timeout: got %0d records pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int base;
        idle(2);
        chk("rst_valid", 64'(tri_valid_out), 64'd0);
        chk("rst_bbox", bbox_out, 64'd0);
        chk("rst_x", 64'(tri_x_out), 64'd0);
        chk("rst_flags", {62'd0, overflow_out, frame_err_out}, 64'd0);
        rst_in = 1'b1;
        idle(1);

        // Basic triangle
        tri_ready_in = 1'b1;
        beat(5, 4, 0, 16'hF800, 1'b0);
        beat(10, 6, 0, 16'h0000, 1'b0);
        beat(7, 4, 1, 16'h0000, 1'b1);
        chk("basic_valid", 64'(tri_valid_out), 64'd1);
        chk("basic_bbox", bbox_out, 64'h0006_0004_000A_0005);
        chk("basic_x", 64'(tri_x_out), 64'h0007_000A_0005);
        chk("basic_color", 64'(tri_color_out), 64'hF800);
        chk("basic_last", 64'(tri_last_out), 64'd1);
        chk("basic_degen", 64'(degen_out), 64'd0);
        idle(1);
        chk("basic_pulse", 64'(tri_valid_out), 64'd0);

        // Degenerate with negative x
        beat(-3, 2, 0, 16'h07E0, 1'b0);
        beat(-3, 7, 0, 16'h0000, 1'b0);
        beat(-3, 9, 0, 16'h0000, 1'b0);
        chk("degen_xmin", 64'(bbox_out[15:0]), 64'hFFFD);
        chk("degen_xmax", 64'(bbox_out[31:16]), 64'hFFFD);
        chk("degen_y", 64'(bbox_out[63:32]), 64'h0009_0002);
        chk("degen_flag", 64'(degen_out), 64'd1);
        idle(2);

        // Backpressure and overflow
        tri_ready_in = 1'b0;
        for (int i = 0; i < 3*(DEPTH+1); i++) rbeat(1'b0);
        idle(1);
        chk("ovf_set", 64'(overflow_out), 64'd1);
        base = n_out;
        drain(60);
        chk("ovf_drained", 64'(n_out - base), 64'(DEPTH));
        chk("ovf_sticky", 64'(overflow_out), 64'd1);

        // Full FIFO with simultaneous pop
        do_reset();
        tri_ready_in = 1'b0;
        for (int i = 0; i < 3*DEPTH; i++) rbeat(1'b0);
        rbeat(1'b0);
        rbeat(1'b0);
        base = n_out;
        tri_ready_in = 1'b1;
        rbeat(1'b0);
        tri_ready_in = 1'b0;
        idle(2);
        chk("full_pop_ovf", 64'(overflow_out), 64'd0);
        drain(60);
        chk("full_pop_count", 64'(n_out - base), 64'(DEPTH + 1));

        // Short frame, then a clean triangle
        do_reset();
        tri_ready_in = 1'b1;
        base = n_out;
        rbeat(1'b0); rbeat(1'b0); rbeat(1'b0);
        rbeat(1'b1);
        idle(1);
        chk("short_ferr", 64'(frame_err_out), 64'd1);
        beat(1, 2, 3, 16'h001F, 1'b0);
        beat(-8, 20, 4, 16'h0000, 1'b0);
        beat(6, -1, 5, 16'h0000, 1'b1);
        chk("short_clean_bbox", bbox_out, 64'h0014_FFFF_0006_FFF8);
        chk("short_clean_color", 64'(tri_color_out), 64'h001F);
        drain(20);
        chk("short_count", 64'(n_out - base), 64'd2);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tri_ready_in = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) rbeat($urandom_range(0, 9) == 0);
            else idle(1);
        end
        drain(100);

        // Async reset mid-stream
        do_reset();
        tri_ready_in = 1'b0;
        for (int i = 0; i < 9; i++) rbeat(1'b0);
        rbeat(1'b0);
        rbeat(1'b0);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_valid", 64'(tri_valid_out), 64'd0);
        chk("arst_x", 64'(tri_x_out), 64'd0);
        chk("arst_y", 64'(tri_y_out), 64'd0);
        chk("arst_z", 64'(tri_z_out), 64'd0);
        chk("arst_bbox", bbox_out, 64'd0);
        chk("arst_misc", {61'd0, degen_out, tri_last_out, (|tri_color_out)}, 64'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        idle(1);
        base = n_out;
        tri_ready_in = 1'b1;
        rbeat(1'b0); rbeat(1'b0); rbeat(1'b0);
        drain(20);
        chk("arst_one_tri", 64'(n_out - base), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
